// File: rtl/sram_like_axi_pkg.sv
// Shared types and AXI constants for the data-side sram-like to AXI3 responder.
package sram_like_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW_W,
        B,
        RESP
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_1B    = 3'd0;
    localparam logic [2:0] SIZE_2B    = 3'd1;
    localparam logic [2:0] SIZE_4B    = 3'd2;

    // Byte-lane enables for a single beat; size 3 is treated as a full word.
    function automatic logic [3:0] size_addr_to_wstrb(input logic [1:0] size,
                                                      input logic [1:0] addr_lo);
        case ({1'b0, size})
            SIZE_1B: return 4'b0001 << addr_lo;
            SIZE_2B: return addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_4B: return 4'b1111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/d_sram_like_to_axi.sv
// Performs one sram-like data transaction at a time as a single-beat AXI3 read or write.
module d_sram_like_to_axi
    import sram_like_axi_pkg::*;
#(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = ID_W'(1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            data_req,
    input  logic            data_wr,
    input  logic [1:0]      data_size,
    input  logic [31:0]     data_addr,
    input  logic [31:0]     data_wdata,
    output logic [31:0]     data_rdata,
    output logic            data_addr_ok,
    output logic            data_data_ok,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [3:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [3:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [1:0]      awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [1:0]  size_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        aw_done_reg, w_done_reg;
    logic        arvalid_reg, rready_reg, awvalid_reg, wvalid_reg, bready_reg;
    logic        data_ok_reg;

    logic aw_hs, w_hs;
    assign aw_hs = awvalid_reg & awready;
    assign w_hs  = wvalid_reg & wready;

    // Response ids, read response code, rlast and write response are deliberately not used.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            size_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            data_ok_reg <= 1'b0;
        end else begin
            data_ok_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (data_req) begin
                        addr_reg  <= data_addr;
                        size_reg  <= data_size;
                        wdata_reg <= data_wdata;
                        if (data_wr) begin
                            state_reg   <= AW_W;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                        end else begin
                            state_reg   <= AR;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        state_reg   <= R;
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                    end
                end
                R: begin
                    if (rvalid) begin
                        state_reg   <= RESP;
                        rready_reg  <= 1'b0;
                        rdata_reg   <= rdata;
                        data_ok_reg <= 1'b1;
                    end
                end
                AW_W: begin
                    // Address and data channels finish independently, in any order.
                    if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) begin
                        state_reg   <= B;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        awvalid_reg <= 1'b0;
                        wvalid_reg  <= 1'b0;
                        bready_reg  <= 1'b1;
                    end else begin
                        if (aw_hs) begin
                            aw_done_reg <= 1'b1;
                            awvalid_reg <= 1'b0;
                        end
                        if (w_hs) begin
                            w_done_reg <= 1'b1;
                            wvalid_reg <= 1'b0;
                        end
                    end
                end
                B: begin
                    if (bvalid) begin
                        state_reg   <= RESP;
                        bready_reg  <= 1'b0;
                        data_ok_reg <= 1'b1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign data_addr_ok = (state_reg == IDLE) & data_req;
    assign data_data_ok = data_ok_reg;
    assign data_rdata   = rdata_reg;

    assign arid    = AXI_ID;
    assign araddr  = addr_reg;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, size_reg};
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = arvalid_reg;
    assign rready  = rready_reg;

    assign awid    = AXI_ID;
    assign awaddr  = addr_reg;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, size_reg};
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = awvalid_reg;

    assign wid    = AXI_ID;
    assign wdata  = wdata_reg;
    assign wstrb  = size_addr_to_wstrb(size_reg, addr_reg[1:0]);
    assign wlast  = 1'b1;
    assign wvalid = wvalid_reg;
    assign bready = bready_reg;

endmodule

// File: tb/tb_d_sram_like_to_axi.sv
// Bench for d_sram_like_to_axi: directed vector table, a reset-abort sequence and random transactions.
module tb_d_sram_like_to_axi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid, awid, wid;
    logic [31:0] araddr, awaddr, wdata;
    logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic        arvalid, rready, awvalid, wlast, wvalid, bready;
    logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b1, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [3:0]  rid = 4'd1, bid = 4'd1;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00, bresp = 2'b00;

    always #5 clk = ~clk;

    d_sram_like_to_axi #(.ID_W(4), .AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  bresp;
        int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
        bit          hold;
        logic [3:0]  exp_wstrb;
        int          exp_lat;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] prev_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Lanes covered by a naturally aligned access of 1, 2 or 4 bytes.
    function automatic logic [3:0] model_wstrb(input logic [1:0] size, input logic [31:0] addr);
        int bytes, off;
        bytes = (size >= 2'd2) ? 4 : (1 << size);
        off   = (int'(addr[1:0]) / bytes) * bytes;
        return 4'(((1 << bytes) - 1) << off);
    endfunction

    // Request cycle + one cycle per address phase wait + data/resp phase wait + response cycle.
    function automatic int model_lat(input vec_t v);
        if (!v.wr) return 3 + v.ar_dly + v.r_dly;
        return 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + v.b_dly;
    endfunction

    task automatic run_txn(input vec_t v, input int idx);
        int          done, m;
        logic [31:0] exp_rd;
        logic        e;
        done   = v.exp_lat;
        m      = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
        exp_rd = v.wr ? prev_rdata : v.rdata;
        for (int c = 0; c <= done + 1; c++) begin
            @(negedge clk);
            data_req   = (c == 0) || (v.hold && c <= done);
            data_wr    = v.wr;
            data_size  = v.size;
            data_addr  = v.addr;
            data_wdata = v.wdata;
            arready    = !v.wr && (c == 1 + v.ar_dly);
            rvalid     = !v.wr && (c == 2 + v.ar_dly + v.r_dly);
            rdata      = rvalid ? v.rdata : $urandom;
            awready    = v.wr && (c == 1 + v.aw_dly);
            wready     = v.wr && (c == 1 + v.w_dly);
            bvalid     = v.wr && (c == 2 + m + v.b_dly);
            bresp      = v.bresp;
            #1;
            check_b("addr_ok", data_addr_ok, c == 0);
            check_b("data_ok", data_data_ok, c == done);
            check("data_rdata", data_rdata, (c < done) ? prev_rdata : exp_rd);
            e = !v.wr && c >= 1 && c <= 1 + v.ar_dly;
            check_b("arvalid", arvalid, e);
            if (e) begin
                check("araddr", araddr, v.addr);
                check("arsize", 32'(arsize), 32'(v.size));
                check("arlen", 32'(arlen), 32'd0);
                check("arburst/arid", {24'd0, arburst, 2'b00, arid}, {24'd0, 2'b01, 2'b00, 4'd1});
            end
            check_b("rready", rready, !v.wr && c >= 2 + v.ar_dly && c <= 2 + v.ar_dly + v.r_dly);
            e = v.wr && c >= 1 && c <= 1 + v.aw_dly;
            check_b("awvalid", awvalid, e);
            if (e) begin
                check("awaddr", awaddr, v.addr);
                check("awsize", 32'(awsize), 32'(v.size));
                check("awlen", 32'(awlen), 32'd0);
            end
            e = v.wr && c >= 1 && c <= 1 + v.w_dly;
            check_b("wvalid", wvalid, e);
            if (e) begin
                check("wdata", wdata, v.wdata);
                check("wstrb", 32'(wstrb), 32'(v.exp_wstrb));
                check_b("wlast", wlast, 1'b1);
            end
            check_b("bready", bready, v.wr && c >= 2 + m && c <= 2 + m + v.b_dly);
        end
        data_req   = 1'b0;
        prev_rdata = exp_rd;
        $display("[TB] txn %0d %s size=%0d addr=%h lat=%0d rdata=%h", idx,
                 v.wr ? "WR" : "RD", v.size, v.addr, done, data_rdata);
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        vecs[0] = '{wr:0, size:2, addr:32'h1000_0004, wdata:0, rdata:32'hDEAD_BEEF, bresp:0,
                    ar_dly:0, r_dly:0, aw_dly:0, w_dly:0, b_dly:0, hold:0, exp_wstrb:4'hF, exp_lat:3};
        vecs[1] = '{wr:1, size:0, addr:32'hBFAF_0003, wdata:32'hAB00_0000, rdata:0, bresp:0,
                    ar_dly:0, r_dly:0, aw_dly:0, w_dly:0, b_dly:0, hold:0, exp_wstrb:4'b1000, exp_lat:3};
        vecs[2] = '{wr:1, size:2, addr:32'h0000_1230, wdata:32'h1234_5678, rdata:0, bresp:0,
                    ar_dly:0, r_dly:0, aw_dly:0, w_dly:3, b_dly:0, hold:0, exp_wstrb:4'hF, exp_lat:6};
        vecs[3] = '{wr:0, size:2, addr:32'h2000_0010, wdata:0, rdata:32'hCAFE_F00D, bresp:0,
                    ar_dly:5, r_dly:0, aw_dly:0, w_dly:0, b_dly:0, hold:1, exp_wstrb:4'hF, exp_lat:8};
        vecs[4] = '{wr:1, size:1, addr:32'h8000_0002, wdata:32'hBEEF_0000, rdata:0, bresp:2'b10,
                    ar_dly:0, r_dly:0, aw_dly:0, w_dly:0, b_dly:0, hold:0, exp_wstrb:4'b1100, exp_lat:3};
        vecs[5] = '{wr:1, size:1, addr:32'h8000_0000, wdata:32'h0000_5A5A, rdata:0, bresp:2'b11,
                    ar_dly:0, r_dly:0, aw_dly:2, w_dly:0, b_dly:1, hold:1, exp_wstrb:4'b0011, exp_lat:6};
        vecs[6] = '{wr:1, size:0, addr:32'h0000_0001, wdata:32'h0000_7700, rdata:0, bresp:0,
                    ar_dly:0, r_dly:0, aw_dly:1, w_dly:1, b_dly:0, hold:0, exp_wstrb:4'b0010, exp_lat:4};
        vecs[7] = '{wr:0, size:0, addr:32'h0000_0003, wdata:0, rdata:32'h5500_0000, bresp:0,
                    ar_dly:0, r_dly:2, aw_dly:0, w_dly:0, b_dly:0, hold:0, exp_wstrb:4'b1000, exp_lat:5};

        // Reset state
        #1;
        check_b("rst arvalid", arvalid, 1'b0);
        check_b("rst awvalid", awvalid, 1'b0);
        check_b("rst wvalid", wvalid, 1'b0);
        check_b("rst rready", rready, 1'b0);
        check_b("rst bready", bready, 1'b0);
        check_b("rst data_ok", data_data_ok, 1'b0);
        check("rst data_rdata", data_rdata, 32'd0);
        check("rst araddr", araddr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Abort a read with reset while it waits in R
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_4440;
        @(negedge clk);
        data_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b0;
        #1;
        check_b("pre-rst rready", rready, 1'b1);
        check("pre-rst data_rdata", data_rdata, prev_rdata);
        #2 rst = 1'b1;
        #1;
        check_b("async rst rready", rready, 1'b0);
        check_b("async rst data_ok", data_data_ok, 1'b0);
        check("async rst data_rdata", data_rdata, 32'd0);
        check_b("async rst arvalid", arvalid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        prev_rdata = '0;
        $display("[TB] reset abort sequence done");
        rv = '{wr:0, size:2, addr:32'h0000_4440, wdata:0, rdata:32'h0BAD_CAFE, bresp:0,
               ar_dly:0, r_dly:0, aw_dly:0, w_dly:0, b_dly:0, hold:0, exp_wstrb:4'hF, exp_lat:3};
        run_txn(rv, 100);

        for (int i = 0; i < 40; i++) begin
            rv.wr     = 1'($urandom_range(0, 1));
            rv.size   = 2'($urandom_range(0, 3));
            rv.addr   = $urandom;
            rv.wdata  = $urandom;
            rv.rdata  = $urandom;
            rv.bresp  = 2'($urandom_range(0, 3));
            rv.ar_dly = $urandom_range(0, 3);
            rv.r_dly  = $urandom_range(0, 3);
            rv.aw_dly = $urandom_range(0, 3);
            rv.w_dly  = $urandom_range(0, 3);
            rv.b_dly  = $urandom_range(0, 3);
            rv.hold   = 1'($urandom_range(0, 1));
            rv.exp_wstrb = model_wstrb(rv.size, rv.addr);
            rv.exp_lat   = model_lat(rv);
            run_txn(rv, 200 + i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
